// File: rtl/assoc_cache_ctrl_if.sv
// assoc_cache_ctrl_if: request, data-array, memory and perf signals of the cache controller
interface assoc_cache_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 2
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int LW    = 8 * LINE_BYTES;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_hit;
    logic [IDX_W-1:0]  arr_index;
    logic [WAY_W-1:0]  arr_way;
    logic              arr_we;
    logic [LW-1:0]     arr_wdata;
    logic [LW-1:0]     arr_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [LW-1:0]     mem_wdata;
    logic [LW-1:0]     mem_rdata;
    logic              mem_ready;
    logic [31:0]       perf_hits;
    logic [31:0]       perf_misses;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, arr_rdata, mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_hit, arr_index, arr_way, arr_we, arr_wdata,
               mem_addr, mem_rd_req, mem_wr_req, mem_wdata, perf_hits, perf_misses
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, arr_rdata, mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_hit, arr_index, arr_way, arr_we, arr_wdata,
               mem_addr, mem_rd_req, mem_wr_req, mem_wdata, perf_hits, perf_misses
    );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: set-associative cache controller with tree pseudo-LRU replacement
module assoc_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 2,
    parameter bit WRITE_BACK = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    assoc_cache_ctrl_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int LW    = 8 * LINE_BYTES;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, EVICT, EVICT_WAIT, FILL, FILL_WAIT, REFILL, WT, WT_WAIT, RESP
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:2]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                write_q;
    logic                hit_q;
    logic [WAY_W-1:0]    victim_q;
    logic [LW-1:0]       line_q;
    logic [31:0]         hits_q;
    logic [31:0]         misses_q;
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    idx;
    logic [OFF_W-3:0]    wsel;
    logic                hit;
    logic                inv;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    plru_vic;
    logic [WAY_W-1:0]    victim;
    logic [WAY_W-1:0]    acc_way;
    logic                plru_we;
    logic [LW-1:0]       merged;
    logic [31:0]         word;
    logic                evict_st;
    logic                line_st;

    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign idx      = addr_q[OFF_W +: IDX_W];
    assign wsel     = addr_q[OFF_W-1:2];
    assign victim   = inv ? inv_way : plru_vic;
    assign acc_way  = state == REFILL ? victim_q : hit_way;
    assign plru_we  = (state == LOOKUP && hit) || state == REFILL;
    assign word     = merged[{wsel, 5'd0} +: 32];
    assign evict_st = state == EVICT || state == EVICT_WAIT;
    assign line_st  = state == FILL || state == FILL_WAIT || state == WT || state == WT_WAIT;

    // tag compare and lowest-numbered invalid way of the addressed set
    always_comb begin
        hit     = 1'b0;
        inv     = 1'b0;
        hit_way = '0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                inv     = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    // line being written back: array line on a hit, fetched line on refill, store word merged in
    always_comb begin
        merged = state == REFILL ? line_q : bus.arr_rdata;
        if (write_q) merged[{wsel, 5'd0} +: 32] = wdata_q;
    end

    if (NUM_WAYS == 1) begin : g_plru
        assign plru_vic = '0;
    end else begin : g_plru
        logic [NUM_WAYS-2:0] plru_q [NUM_SETS];
        logic [NUM_WAYS-2:0] cur;
        logic [NUM_WAYS-2:0] nxt;
        assign cur = plru_q[idx];
        if (NUM_WAYS == 2) begin : g_t
            assign plru_vic = cur[0];
            assign nxt      = ~acc_way[0];
        end else begin : g_t
            assign plru_vic = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
            assign nxt      = acc_way[1] ? {~acc_way[0], cur[1], 1'b0} : {cur[2], ~acc_way[0], 1'b1};
        end
        // tree bits turned away from the way just touched
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
            end else if (plru_we) begin
                plru_q[idx] <= nxt;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = bus.req_valid ? LOOKUP : IDLE;
            LOOKUP:     state_nxt = hit ? (write_q && !WRITE_BACK ? WT : RESP)
                                        : (valid_q[idx][victim] && dirty_q[idx][victim] ? EVICT : FILL);
            EVICT:      state_nxt = EVICT_WAIT;
            EVICT_WAIT: state_nxt = bus.mem_ready ? FILL : EVICT_WAIT;
            FILL:       state_nxt = FILL_WAIT;
            FILL_WAIT:  state_nxt = bus.mem_ready ? REFILL : FILL_WAIT;
            REFILL:     state_nxt = write_q && !WRITE_BACK ? WT : RESP;
            WT:         state_nxt = WT_WAIT;
            WT_WAIT:    state_nxt = bus.mem_ready ? RESP : WT_WAIT;
            RESP:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // request latch, line buffer, response, valid/dirty and perf counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            victim_q <= '0;
            line_q   <= '0;
            rdata_q  <= '0;
            hit_q    <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (state == IDLE && bus.req_valid) begin
                addr_q  <= bus.req_addr[ADDR_W-1:2];
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end
            if (state == LOOKUP) begin
                victim_q <= victim;
                hit_q    <= hit;
                if (hit) begin
                    rdata_q <= word;
                    line_q  <= merged;
                    hits_q  <= hits_q + {31'd0, ~&hits_q};
                    if (write_q && WRITE_BACK) dirty_q[idx][hit_way] <= 1'b1;
                end else begin
                    misses_q <= misses_q + {31'd0, ~&misses_q};
                end
            end
            if (state == FILL_WAIT && bus.mem_ready) line_q <= bus.mem_rdata;
            if (state == REFILL) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= write_q && WRITE_BACK;
                rdata_q                <= word;
                hit_q                  <= 1'b0;
                line_q                 <= merged;
            end
        end
    end

    // tags change only when a fetched line lands
    always_ff @(posedge clk) begin
        if (state == REFILL) tag_q[idx][victim_q] <= tag;
    end

    assign bus.req_ready   = state == IDLE;
    assign bus.rsp_valid   = state == RESP;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_hit     = hit_q;
    assign bus.arr_index   = idx;
    assign bus.arr_way     = state == LOOKUP ? hit_way : victim_q;
    assign bus.arr_we      = (state == LOOKUP && hit && write_q) || state == REFILL;
    assign bus.arr_wdata   = merged;
    assign bus.mem_rd_req  = state == FILL;
    assign bus.mem_wr_req  = state == EVICT || state == WT;
    assign bus.mem_addr    = evict_st ? {tag_q[idx][victim_q], idx, OFF_W'(0)}
                           : line_st ? {tag, idx, OFF_W'(0)} : '0;
    assign bus.mem_wdata   = evict_st ? bus.arr_rdata
                           : (state == WT || state == WT_WAIT) ? line_q : '0;
    assign bus.perf_hits   = hits_q;
    assign bus.perf_misses = misses_q;
endmodule

// File: doc/assoc_cache_ctrl.md
ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, physical address width.
- LINE_BYTES, 64, line size; power of 2, at least 8.
- NUM_SETS, 64, set count; power of 2.
- NUM_WAYS, 2, associativity; one of 1, 2, 4.
- WRITE_BACK, 0, write policy: 0 = write-through, 1 = write-back with dirty bits.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset. Asynchronous, active-low.
- req_valid / req_write, in, 1 each, request strobe and write flag.
- req_addr, in, ADDR_W, byte address.
- req_wdata, in, 32, store word.
- req_ready, out, 1, controller can accept a request.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_rdata, out, 32, load data.
- rsp_hit, out, 1, the request hit.
- arr_index, out, log2 NUM_SETS, data-array set.
- arr_way, out, max(1, log2 NUM_WAYS), data-array way.
- arr_we, out, 1, data-array write enable.
- arr_wdata, out, 8*LINE_BYTES, data-array write line.
- arr_rdata, in, 8*LINE_BYTES, data-array read line; combinational from arr_index/arr_way.
- mem_addr, out, ADDR_W, line-aligned memory address.
- mem_rd_req / mem_wr_req, out, 1 each, one-cycle request pulses.
- mem_wdata, out, 8*LINE_BYTES, memory write line.
- mem_rdata, in, 8*LINE_BYTES, memory read line.
- mem_ready, in, 1, one-cycle completion pulse.
- perf_hits / perf_misses, out, 32 each, saturating counters.

Function
REQ-003 Address split SHALL be: offset = low log2(LINE_BYTES) bits; index = next log2(NUM_SETS) bits; tag = remainder; word select = offset[msb:2].
REQ-004 Per set and way, the controller SHALL hold tag, valid and dirty registers; dirty SHALL be constant 0 when WRITE_BACK=0.
REQ-005 Per set, the controller SHALL hold a tree pseudo-LRU of NUM_WAYS-1 bits; it is absent when NUM_WAYS=1.
REQ-006 FSM states SHALL be IDLE, LOOKUP, EVICT, EVICT_WAIT, FILL, FILL_WAIT, REFILL, WT, WT_WAIT and RESP.
REQ-007 req_ready SHALL be 1 only in IDLE.
REQ-008 A request SHALL be accepted when req_valid && req_ready; addr, wdata and write are latched, and the next state is LOOKUP.
REQ-009 LOOKUP, read hit: load the hit word into rsp_rdata, set rsp_hit=1, update PLRU, go to RESP; rsp_valid is asserted 2 cycles after acceptance.
REQ-010 LOOKUP, write hit:
- write the arr_rdata line, with the addressed word replaced, to the hit way (arr_we=1);
- update PLRU;
- WRITE_BACK=1: set dirty, go to RESP;
- WRITE_BACK=0: go to WT.
REQ-011 LOOKUP, miss: victim = lowest-numbered invalid way, else the PLRU way.
- If the victim is valid and dirty, go to EVICT; otherwise go to FILL.
- Write misses allocate in both modes.
REQ-012 EVICT SHALL pulse mem_wr_req with mem_addr = {victim tag, index, 0} and mem_wdata = the victim line; EVICT_WAIT waits for mem_ready, then goes to FILL.
REQ-013 FILL SHALL pulse mem_rd_req with the line-aligned request address; FILL_WAIT latches mem_rdata on mem_ready.
REQ-014 REFILL SHALL:
- write the fetched line to the victim way, merging the store word on writes;
- set tag and valid=1;
- set dirty = write && WRITE_BACK;
- update PLRU;
- drive rsp_rdata = the addressed word and rsp_hit=0;
- go to WT on a write with WRITE_BACK=0, else to RESP.
REQ-015 WT SHALL pulse mem_wr_req with the merged line at the line address; WT_WAIT waits for mem_ready, then goes to RESP.
REQ-016 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE.
REQ-017 mem_ready outside the *_WAIT states SHALL be ignored. The memory-wait states SHALL have no timeout.
REQ-018 perf_hits / perf_misses SHALL increment once per LOOKUP outcome and saturate at 0xFFFFFFFF.
REQ-019 PLRU update SHALL point away from the accessed way. For NUM_WAYS=2 this reduces to a single bit equal to the other way.

Reset
REQ-020 On rst_n low, regardless of state:
- state = IDLE;
- all valid, dirty and PLRU bits = 0;
- rsp_valid, rsp_hit, rsp_rdata, arr_we, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, perf counters = 0;
- req_ready = 1.
REQ-021 Reset during any memory wait SHALL abandon the transaction. No tag, valid or dirty bit SHALL be changed by the abandoned request, and a later mem_ready SHALL be ignored.

Verification
REQ-022 Default parameters, cold read of 0x0000_1004 -> mem_rd_req with mem_addr 0x0000_1000; memory returns a line whose word1 = 0xCAFE_F00D -> rsp_valid with rdata 0xCAFE_F00D and hit=0, perf_misses=1.
REQ-023 Repeat the read of 0x0000_1004 -> rsp_valid 2 cycles after acceptance, hit=1, no memory request, perf_hits=1.
REQ-024 WRITE_BACK=0, write 0x1234_5678 to 0x0000_1008 (hit) -> arr_we and mem_wr_req at 0x0000_1000 with word2 = 0x1234_5678; rsp_valid follows mem_ready.
REQ-025 WRITE_BACK=1, NUM_WAYS=2:
- write hit on 0x0000_1000 -> no memory traffic;
- fill 0x0000_2000 (same set, other way);
- read 0x0000_3000 -> eviction of the dirty 0x0000_1000 line (mem_wr_req) precedes mem_rd_req of 0x0000_3000.
REQ-026 NUM_WAYS=4, fill 5 lines mapping to set 0 with no re-reference -> the 5th fill replaces way 0 (PLRU order 0, 2, 1, 3).
REQ-027 Assert rst_n during FILL_WAIT, then reissue the read -> miss again; the stale mem_ready pulse causes no state change.
